// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - EX/MEM input slot, stall and MEM/WB output bundle for mem_stage_lsu
interface mem_stage_lsu_if;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_mem_data;
    logic [31:0] out_alu_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_to_reg;
    logic        out_misaligned;

    modport master (
        output in_valid, in_mem_read, in_mem_write, in_funct3, in_alu_result,
               in_rs2_data, in_rd, in_reg_write, in_mem_to_reg,
        input  stall, out_valid, out_mem_data, out_alu_result, out_rd,
               out_reg_write, out_mem_to_reg, out_misaligned
    );

    modport slave (
        input  in_valid, in_mem_read, in_mem_write, in_funct3, in_alu_result,
               in_rs2_data, in_rd, in_reg_write, in_mem_to_reg,
        output stall, out_valid, out_mem_data, out_alu_result, out_rd,
               out_reg_write, out_mem_to_reg, out_misaligned
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage with RV32I load/store unit, wait-state FSM and byte-enabled data RAM
module mem_stage_lsu #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_lsu_if.slave bus
);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [31:0]           ram [DEPTH];

    logic                  mem_op;
    logic                  is_store;
    logic                  is_load;
    logic                  aligned;
    logic                  misaligned;
    logic                  access;
    logic                  complete;
    logic                  stall_c;
    logic [1:0]            boff;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           rdata;
    logic [31:0]           load_data;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic [7:0]            lbyte;
    logic [15:0]           lhalf;

    assign boff     = bus.in_alu_result[1:0];
    assign widx     = bus.in_alu_result[ADDR_WIDTH+1:2];
    assign mem_op   = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
    assign is_store = bus.in_mem_write;
    assign is_load  = bus.in_mem_read & ~bus.in_mem_write;
    assign rdata    = ram[widx];

    // Reserved widths fall through to misaligned so they are dropped, never executed.
    always_comb begin
        aligned = 1'b0;
        case (bus.in_funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~boff[0];
            3'b010:         aligned = (boff == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    assign misaligned = mem_op & ~aligned;
    assign access     = mem_op & aligned;
    assign complete   = access & ((WAIT_N == 4'd0) | ((state == WAIT) & (cnt == WAIT_N)));
    assign stall_c    = ~reset & access & ~complete;
    assign bus.stall  = stall_c;

    always_comb begin
        lbyte     = rdata[{boff, 3'b000} +: 8];
        lhalf     = boff[1] ? rdata[31:16] : rdata[15:0];
        load_data = 32'd0;
        case (bus.in_funct3)
            3'b000:  load_data = {{24{lbyte[7]}}, lbyte};
            3'b100:  load_data = {24'd0, lbyte};
            3'b001:  load_data = {{16{lhalf[15]}}, lhalf};
            3'b101:  load_data = {16'd0, lhalf};
            3'b010:  load_data = rdata;
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        wdata = bus.in_rs2_data;
        be    = 4'b1111;
        case (bus.in_funct3[1:0])
            2'b00: begin
                wdata = {4{bus.in_rs2_data[7:0]}};
                be    = 4'b0001 << boff;
            end
            2'b01: begin
                wdata = {2{bus.in_rs2_data[15:0]}};
                be    = boff[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Store commits only on the completing edge; a reset during WAIT abandons it.
    always_ff @(posedge clk) begin
        if (!reset && complete && is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= 4'd0;
            bus.out_valid      <= 1'b0;
            bus.out_mem_data   <= 32'd0;
            bus.out_alu_result <= 32'd0;
            bus.out_rd         <= 5'd0;
            bus.out_reg_write  <= 1'b0;
            bus.out_mem_to_reg <= 1'b0;
            bus.out_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && WAIT_N != 4'd0) begin
                        state <= WAIT;
                        cnt   <= 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_N) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase

            bus.out_valid      <= 1'b0;
            bus.out_mem_data   <= 32'd0;
            bus.out_alu_result <= 32'd0;
            bus.out_rd         <= 5'd0;
            bus.out_reg_write  <= 1'b0;
            bus.out_mem_to_reg <= 1'b0;
            bus.out_misaligned <= 1'b0;
            if (bus.in_valid && !stall_c) begin
                bus.out_valid      <= 1'b1;
                bus.out_alu_result <= bus.in_alu_result;
                bus.out_rd         <= bus.in_rd;
                bus.out_mem_to_reg <= bus.in_mem_to_reg;
                bus.out_reg_write  <= bus.in_reg_write & ~misaligned;
                bus.out_misaligned <= misaligned;
                bus.out_mem_data   <= (access && is_load) ? load_data : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu (0 and 3 wait states, 4-bit address wrap)
module tb_mem_stage_lsu;
    logic        clk;
    logic        reset;
    int          sel;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    int          n_cmp;
    int          n_bad;

    mem_stage_lsu_if if0();
    mem_stage_lsu_if if3();
    mem_stage_lsu_if ifw();

    assign if0.in_valid = in_valid && (sel == 0);
    assign if3.in_valid = in_valid && (sel == 1);
    assign ifw.in_valid = in_valid && (sel == 2);
    assign if0.in_mem_read = in_mem_read;     assign if3.in_mem_read = in_mem_read;     assign ifw.in_mem_read = in_mem_read;
    assign if0.in_mem_write = in_mem_write;   assign if3.in_mem_write = in_mem_write;   assign ifw.in_mem_write = in_mem_write;
    assign if0.in_funct3 = in_funct3;         assign if3.in_funct3 = in_funct3;         assign ifw.in_funct3 = in_funct3;
    assign if0.in_alu_result = in_alu_result; assign if3.in_alu_result = in_alu_result; assign ifw.in_alu_result = in_alu_result;
    assign if0.in_rs2_data = in_rs2_data;     assign if3.in_rs2_data = in_rs2_data;     assign ifw.in_rs2_data = in_rs2_data;
    assign if0.in_rd = in_rd;                 assign if3.in_rd = in_rd;                 assign ifw.in_rd = in_rd;
    assign if0.in_reg_write = in_reg_write;   assign if3.in_reg_write = in_reg_write;   assign ifw.in_reg_write = in_reg_write;
    assign if0.in_mem_to_reg = in_mem_to_reg; assign if3.in_mem_to_reg = in_mem_to_reg; assign ifw.in_mem_to_reg = in_mem_to_reg;

    mem_stage_lsu #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(reset), .bus(if0));
    mem_stage_lsu #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .reset(reset), .bus(if3));
    mem_stage_lsu #(.ADDR_WIDTH(4),  .WAIT_CYCLES(0)) u_wr (.clk(clk), .reset(reset), .bus(ifw));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic v, input logic rw, input logic mis,
                            input logic m2r, input logic [4:0] rdx, input logic [31:0] md,
                            input logic [31:0] alu);
        chk({tag, " out_valid"}, 32'(v), 32'd0);
        chk({tag, " out_reg_write"}, 32'(rw), 32'd0);
        chk({tag, " out_misaligned"}, 32'(mis), 32'd0);
        chk({tag, " out_mem_to_reg"}, 32'(m2r), 32'd0);
        chk({tag, " out_rd"}, 32'(rdx), 32'd0);
        chk({tag, " out_mem_data"}, md, 32'd0);
        chk({tag, " out_alu_result"}, alu, 32'd0);
    endtask

    task automatic set_op(input int s, input logic v, input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rdx, input logic rw, input logic m2r);
        sel           = s;
        in_valid      = v;
        in_mem_read   = r;
        in_mem_write  = w;
        in_funct3     = f3;
        in_alu_result = a;
        in_rs2_data   = d;
        in_rd         = rdx;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
    endtask

    // Single-cycle op on the zero-wait DUT selected by s; stall must stay low.
    task automatic op1(input string tag, input int s, input logic r, input logic w,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rdx, input logic rw);
        set_op(s, 1'b1, r, w, f3, a, d, rdx, rw, r);
        #1;
        chk({tag, " stall"}, 32'(s == 0 ? if0.stall : ifw.stall), 32'd0);
        tick();
    endtask

    // Aligned memory op on the 3-wait DUT: stall for exactly three cycles with bubbles out.
    task automatic op3(input string tag, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdx);
        set_op(1, 1'b1, r, w, f3, a, d, rdx, r, r);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s stall c%0d", tag, i), 32'(if3.stall), 32'd1);
            tick();
            chk($sformatf("%s out_valid c%0d", tag, i), 32'(if3.out_valid), 32'd0);
        end
        chk({tag, " stall final"}, 32'(if3.stall), 32'd0);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        set_op(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_op(1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd4, 1'b1, 1'b1);
        #1;
        chk("reset stall w3", 32'(if3.stall), 32'd0);
        tick();
        chk_zero("reset w0", if0.out_valid, if0.out_reg_write, if0.out_misaligned,
                 if0.out_mem_to_reg, if0.out_rd, if0.out_mem_data, if0.out_alu_result);
        chk_zero("reset w3", if3.out_valid, if3.out_reg_write, if3.out_misaligned,
                 if3.out_mem_to_reg, if3.out_rd, if3.out_mem_data, if3.out_alu_result);
        reset = 1'b0;
        in_valid = 1'b0;
        tick();

        op1("sw 10", 0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
        chk("sw 10 out_valid", 32'(if0.out_valid), 32'd1);
        chk("sw 10 out_reg_write", 32'(if0.out_reg_write), 32'd0);
        op1("lw 10", 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 5'd5, 1'b1);
        chk("lw 10 data", if0.out_mem_data, 32'hDEADBEEF);
        chk("lw 10 rd", 32'(if0.out_rd), 32'd5);
        chk("lw 10 reg_write", 32'(if0.out_reg_write), 32'd1);
        chk("lw 10 mem_to_reg", 32'(if0.out_mem_to_reg), 32'd1);
        chk("lw 10 alu", if0.out_alu_result, 32'h10);

        op1("sw 20", 0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 5'd0, 1'b0);
        op1("sb 21", 0, 1'b0, 1'b1, 3'b000, 32'h21, 32'h12345680, 5'd0, 1'b0);
        op1("lb 21", 0, 1'b1, 1'b0, 3'b000, 32'h21, 32'd0, 5'd6, 1'b1);
        chk("lb 21 data", if0.out_mem_data, 32'hFFFFFF80);
        op1("lbu 21", 0, 1'b1, 1'b0, 3'b100, 32'h21, 32'd0, 5'd6, 1'b1);
        chk("lbu 21 data", if0.out_mem_data, 32'h00000080);
        op1("sh 22", 0, 1'b0, 1'b1, 3'b001, 32'h22, 32'hFFFF8001, 5'd0, 1'b0);
        op1("lh 22", 0, 1'b1, 1'b0, 3'b001, 32'h22, 32'd0, 5'd6, 1'b1);
        chk("lh 22 data", if0.out_mem_data, 32'hFFFF8001);
        op1("lhu 22", 0, 1'b1, 1'b0, 3'b101, 32'h22, 32'd0, 5'd6, 1'b1);
        chk("lhu 22 data", if0.out_mem_data, 32'h00008001);
        op1("lw 20", 0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd6, 1'b1);
        chk("lw 20 data", if0.out_mem_data, 32'h80018000);

        op1("sw 00", 0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h11223344, 5'd0, 1'b0);
        op1("lw 02", 0, 1'b1, 1'b0, 3'b010, 32'h2, 32'd0, 5'd7, 1'b1);
        chk("lw 02 out_valid", 32'(if0.out_valid), 32'd1);
        chk("lw 02 reg_write", 32'(if0.out_reg_write), 32'd0);
        chk("lw 02 misaligned", 32'(if0.out_misaligned), 32'd1);
        chk("lw 02 data", if0.out_mem_data, 32'd0);
        op1("sh 01", 0, 1'b0, 1'b1, 3'b001, 32'h1, 32'h0000BEEF, 5'd0, 1'b0);
        chk("sh 01 out_valid", 32'(if0.out_valid), 32'd1);
        chk("sh 01 misaligned", 32'(if0.out_misaligned), 32'd1);
        op1("ld 00 reserved", 0, 1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 5'd7, 1'b1);
        chk("reserved misaligned", 32'(if0.out_misaligned), 32'd1);
        chk("reserved reg_write", 32'(if0.out_reg_write), 32'd0);
        op1("lw 00", 0, 1'b1, 1'b0, 3'b010, 32'h0, 32'd0, 5'd7, 1'b1);
        chk("lw 00 data", if0.out_mem_data, 32'h11223344);
        chk("lw 00 misaligned", 32'(if0.out_misaligned), 32'd0);

        in_valid = 1'b0;
        tick();
        chk("bubble out_valid", 32'(if0.out_valid), 32'd0);
        chk("bubble misaligned", 32'(if0.out_misaligned), 32'd0);

        op3("w3 sw 40", 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd0);
        chk("w3 sw 40 out_valid", 32'(if3.out_valid), 32'd1);
        op3("w3 lw 40", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd9);
        chk("w3 lw 40 out_valid", 32'(if3.out_valid), 32'd1);
        chk("w3 lw 40 data", if3.out_mem_data, 32'hCAFEF00D);
        chk("w3 lw 40 rd", 32'(if3.out_rd), 32'd9);
        set_op(1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h77, 5'd3, 1'b1, 1'b0);
        #1;
        chk("w3 add stall", 32'(if3.stall), 32'd0);
        tick();
        chk("w3 add out_valid", 32'(if3.out_valid), 32'd1);
        chk("w3 add alu", if3.out_alu_result, 32'h55);
        chk("w3 add data", if3.out_mem_data, 32'd0);
        chk("w3 add reg_write", 32'(if3.out_reg_write), 32'd1);

        set_op(1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678, 5'd0, 1'b0, 1'b0);
        #1;
        chk("w3 rst stall c0", 32'(if3.stall), 32'd1);
        tick();
        chk("w3 rst stall c1", 32'(if3.stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("w3 rst stall in reset", 32'(if3.stall), 32'd0);
        tick();
        chk_zero("w3 mid-wait reset", if3.out_valid, if3.out_reg_write, if3.out_misaligned,
                 if3.out_mem_to_reg, if3.out_rd, if3.out_mem_data, if3.out_alu_result);
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        op3("w3 lw 40 after rst", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd9);
        chk("w3 lw 40 after rst data", if3.out_mem_data, 32'hCAFEF00D);

        op1("wrap sw 44", 2, 1'b0, 1'b1, 3'b010, 32'h44, 32'hA5A55A5A, 5'd0, 1'b0);
        op1("wrap lw 04", 2, 1'b1, 1'b0, 3'b010, 32'h04, 32'd0, 5'd1, 1'b1);
        chk("wrap lw 04 data", ifw.out_mem_data, 32'hA5A55A5A);

        in_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
